// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: oversampled I2C target serving a small 8-bit register bank.
module i2c_slave_regs #(
   parameter logic [6:0] SLAVE_ADDR  = 7'b1110000,
   parameter int         NUM_REGS    = 4,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        scl,
   input  logic                        sda_in,
   output logic                        sda_oe,
   output logic [8*NUM_REGS-1:0]       regs_out,
   output logic                        wr_strobe,
   output logic [$clog2(NUM_REGS)-1:0] wr_index,
   output logic                        busy
);
   localparam int PW = $clog2(NUM_REGS);
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;
   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic                    scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [7:0]              sh_q, sh_d;
   logic [PW-1:0]           ptr_q, ptr_d, ptr_inc;
   logic [8*NUM_REGS-1:0]   regs_q, regs_d;
   logic                    sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
   logic [PW-1:0]           wr_index_q, wr_index_d;
   logic                    s_scl, s_sda, scl_rise, scl_fall, start, stop;
   logic [7:0]              byte_in, cur_byte, nxt_byte;
   assign s_scl    = scl_sync_q[SYNC_STAGES-1];
   assign s_sda    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = s_scl & ~scl_prev_q;
   assign scl_fall = ~s_scl & scl_prev_q;
   assign start    = s_scl & scl_prev_q & sda_prev_q & ~s_sda;
   assign stop     = s_scl & scl_prev_q & ~sda_prev_q & s_sda;
   assign byte_in  = {sh_q[6:0], s_sda};
   assign ptr_inc  = ptr_q + PW'(1);
   assign cur_byte = regs_q[{ptr_q, 3'b000} +: 8];
   assign nxt_byte = regs_q[{ptr_inc, 3'b000} +: 8];
   assign sda_oe    = sda_oe_q;
   assign regs_out  = regs_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_index  = wr_index_q;
   assign busy      = busy_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         scl_sync_q  <= '1;
         sda_sync_q  <= '1;
         scl_prev_q  <= 1'b1;
         sda_prev_q  <= 1'b1;
         cnt_q       <= '0;
         sh_q        <= '0;
         ptr_q       <= '0;
         regs_q      <= '0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_index_q  <= '0;
      end else begin
         state_q     <= state_d;
         scl_sync_q  <= scl_sync_d;
         sda_sync_q  <= sda_sync_d;
         scl_prev_q  <= scl_prev_d;
         sda_prev_q  <= sda_prev_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         ptr_q       <= ptr_d;
         regs_q      <= regs_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         wr_index_q  <= wr_index_d;
      end
   end
   always_comb begin
      scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_d  = s_scl;
      sda_prev_d  = s_sda;
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      ptr_d       = ptr_q;
      regs_d      = regs_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      wr_strobe_d = 1'b0;
      wr_index_d  = wr_index_q;
      if (start) begin
         state_d  = ADDR;
         cnt_d    = '0;
         busy_d   = 1'b1;
         sda_oe_d = 1'b0;
      end else if (stop) begin
         state_d  = IDLE;
         cnt_d    = '0;
         busy_d   = 1'b0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ADDR, PTR, WDATA: if (scl_rise) begin
               sh_d  = byte_in;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_d = '0;
                  if (state_q == ADDR) state_d = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                  else if (state_q == PTR) begin
                     ptr_d   = byte_in[PW-1:0];
                     state_d = PTR_ACK;
                  end else begin
                     regs_d[{ptr_q, 3'b000} +: 8] = byte_in;
                     wr_strobe_d = 1'b1;
                     wr_index_d  = ptr_q;
                     ptr_d       = ptr_inc;
                     state_d     = WDATA_ACK;
                  end
               end
            end
            // first fall pulls SDA for the ACK, second fall ends the slot
            ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
               sda_oe_d = ~sda_oe_q;
               if (sda_oe_q) begin
                  state_d = (state_q != ADDR_ACK) ? WDATA : (sh_q[0] ? RDATA : PTR);
                  if (state_q == ADDR_ACK && sh_q[0]) begin
                     sh_d     = cur_byte;
                     sda_oe_d = ~cur_byte[7];
                  end
               end
            end
            // cnt 0 on a fall means the byte was loaded at the master-ACK rise
            RDATA: if (scl_rise) cnt_d = cnt_q + 4'd1;
            else if (scl_fall) begin
               if (cnt_q == 4'd8) begin
                  sda_oe_d = 1'b0;
                  state_d  = RDATA_ACK;
               end else if (cnt_q == 4'd0) sda_oe_d = ~sh_q[7];
               else begin
                  sh_d     = {sh_q[6:0], 1'b0};
                  sda_oe_d = ~sh_q[6];
               end
            end
            RDATA_ACK: if (scl_rise) begin
               if (s_sda) state_d = IGNORE;
               else begin
                  ptr_d   = ptr_inc;
                  sh_d    = nxt_byte;
                  cnt_d   = '0;
                  state_d = RDATA;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bit-banged I2C master against a transaction-level register model.
module tb_i2c_slave_regs;
   localparam int NR = 4;
   localparam int Q  = 50;
   logic        clk = 1'b0, reset = 1'b1, scl = 1'b1, m_sda = 1'b1;
   logic        sda_in, sda_oe, wr_strobe, busy;
   logic [31:0] regs_out;
   logic [1:0]  wr_index;
   int          total = 0, bad = 0, oe_hi = 0;
   int          strobes[$];
   logic [7:0]  mregs[NR];
   int          mptr = 0;
   assign sda_in = m_sda & ~sda_oe;
   always #5 clk = ~clk;
   i2c_slave_regs dut (
      .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
      .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
   );
   always @(negedge clk) begin
      if (sda_oe) oe_hi <= oe_hi + 1;
      if (wr_strobe) strobes.push_back(int'(wr_index));
   end
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic check_regs(input string tag);
      logic [31:0] e;
      for (int i = 0; i < NR; i++) e[8*i +: 8] = mregs[i];
      check(tag, 64'(regs_out), 64'(e));
   endtask
   task automatic send_bit(input logic b);
      m_sda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
   endtask
   task automatic do_start();
      m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
   endtask
   task automatic do_stop();
      m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q;
   endtask
   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      m_sda = 1'b1; #Q; scl = 1'b1; #Q; ack = sda_in; #Q; scl = 1'b0; #Q;
   endtask
   task automatic recv_byte(output logic [7:0] b, input logic mack);
      for (int i = 7; i >= 0; i--) begin
         m_sda = 1'b1; #Q; scl = 1'b1; #Q; b[i] = sda_in; #Q; scl = 1'b0; #Q;
      end
      send_bit(mack);
   endtask
   task automatic write_txn(input logic [7:0] pb, input logic [31:0] data, input int n);
      logic a;
      int s0, exp_idx[$];
      s0 = strobes.size();
      do_start();
      check("busy_start", 64'(busy), 64'(1));
      send_byte(8'hE0, a); check("w_addr_ack", 64'(a), 64'(0));
      send_byte(pb, a);    check("w_ptr_ack", 64'(a), 64'(0));
      mptr = int'(pb) % NR;
      for (int i = 0; i < n; i++) begin
         send_byte(data[8*i +: 8], a);
         check($sformatf("w_data_ack%0d", i), 64'(a), 64'(0));
         exp_idx.push_back(mptr);
         mregs[mptr] = data[8*i +: 8];
         mptr = (mptr + 1) % NR;
      end
      do_stop();
      check("busy_stop", 64'(busy), 64'(0));
      check("strobe_cnt", 64'(strobes.size() - s0), 64'(n));
      for (int i = 0; i < n && s0 + i < strobes.size(); i++)
         check($sformatf("wr_index%0d", i), 64'(strobes[s0+i]), 64'(exp_idx[i]));
      check_regs("regs_after_write");
   endtask
   task automatic read_txn(input logic set_ptr, input logic [7:0] pb, input int n);
      logic a;
      logic [7:0] b;
      do_start();
      if (set_ptr) begin
         send_byte(8'hE0, a); check("r_waddr_ack", 64'(a), 64'(0));
         send_byte(pb, a);    check("r_ptr_ack", 64'(a), 64'(0));
         mptr = int'(pb) % NR;
         do_start();
      end
      send_byte(8'hE1, a); check("r_addr_ack", 64'(a), 64'(0));
      for (int i = 0; i < n; i++) begin
         recv_byte(b, i == n - 1);
         check($sformatf("rd_byte%0d", i), 64'(b), 64'(mregs[mptr]));
         if (i < n - 1) mptr = (mptr + 1) % NR;
      end
      check("oe_after_nack", 64'(sda_oe), 64'(0));
      repeat (10) @(negedge clk);
      check("oe_held_low", 64'(sda_oe), 64'(0));
      do_stop();
      check("busy_rd_stop", 64'(busy), 64'(0));
      check_regs("regs_after_read");
   endtask
   task automatic bad_addr_txn(input logic [7:0] ad);
      logic a;
      int s0, o0;
      s0 = strobes.size();
      o0 = oe_hi;
      do_start();
      send_byte(ad, a);    check("nm_addr_nack", 64'(a), 64'(1));
      send_byte(8'h00, a); check("nm_b1_nack", 64'(a), 64'(1));
      send_byte(8'hFF, a); check("nm_b2_nack", 64'(a), 64'(1));
      do_stop();
      check("nm_oe_never", 64'(oe_hi - o0), 64'(0));
      check("nm_no_strobe", 64'(strobes.size() - s0), 64'(0));
      check_regs("nm_regs");
   endtask
   initial begin
      logic a;
      logic [7:0] ad;
      int s0;
      for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
      repeat (4) @(posedge clk);
      #1;
      check("rst_oe", 64'(sda_oe), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_strobe", 64'(wr_strobe), 64'(0));
      check("rst_regs", 64'(regs_out), 64'(0));
      reset = 1'b0;
      #(2*Q);
      write_txn(8'h01, 32'h000000B2, 1);
      write_txn(8'h03, 32'h00002211, 2);
      write_txn(8'h01, 32'h00005AB2, 2);
      read_txn(1'b1, 8'h01, 2);
      bad_addr_txn(8'hE2);
      // STOP in the middle of a data byte
      s0 = strobes.size();
      do_start();
      send_byte(8'hE0, a); check("mid_addr_ack", 64'(a), 64'(0));
      send_byte(8'h00, a); check("mid_ptr_ack", 64'(a), 64'(0));
      mptr = 0;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      do_stop();
      check("mid_no_strobe", 64'(strobes.size() - s0), 64'(0));
      check("mid_busy", 64'(busy), 64'(0));
      check_regs("mid_regs");
      write_txn(8'h00, 32'h00000077, 1);
      for (int t = 0; t < 14; t++) begin
         case ($urandom_range(0, 4))
            0, 1: write_txn(8'($urandom_range(0, 255)), $urandom(), $urandom_range(1, 3));
            2: read_txn(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 3));
            3: read_txn(1'b0, 8'h00, $urandom_range(1, 3));
            default: begin
               ad = 8'($urandom_range(0, 255));
               while (ad[7:1] == 7'h70) ad = 8'($urandom_range(0, 255));
               bad_addr_txn(ad);
            end
         endcase
      end
      // async reset while the target is driving a zero bit
      write_txn(8'h00, 32'h00000000, 1);
      write_txn(8'h02, 32'h000000C3, 1);
      do_start();
      send_byte(8'hE0, a);
      send_byte(8'h00, a);
      do_start();
      send_byte(8'hE1, a); check("ar_addr_ack", 64'(a), 64'(0));
      for (int i = 0; i < 40 && !sda_oe; i++) @(negedge clk);
      check("ar_oe_before", 64'(sda_oe), 64'(1));
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("ar_oe_async", 64'(sda_oe), 64'(0));
      check("ar_busy", 64'(busy), 64'(0));
      check("ar_regs", 64'(regs_out), 64'(0));
      for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
      mptr = 0;
      scl = 1'b1;
      m_sda = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #(2*Q);
      read_txn(1'b0, 8'h00, 1);
      write_txn(8'h02, 32'h0000003C, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
I2C target (slave) register bank that sits directly downstream of the team's I2C master on the shared SDA/SCL bus. It decodes a 7-bit target address and a register-pointer byte, and serves writes and reads of a small 8-bit register bank. It is oversampled on the system clock; no logic is clocked by SCL. The register outputs feed the configuration logic.

Parameters:
SLAVE_ADDR, 7'b1110000, 7-bit bus address this target responds to.
NUM_REGS, 4, number of 8-bit registers; power of two, 2..16.
SYNC_STAGES, 2, synchronizer flops on scl and sda_in; minimum 2.

Ports:
clk  in  1  system clock; must be at least 8x the SCL rate.
reset  in  1  asynchronous, active-high reset.
scl  in  1  bus clock, read only.
sda_in  in  1  bus data as seen on the pin.
sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
regs_out  out  8*NUM_REGS  flattened register bank; reg i is bits [8i+7:8i].
wr_strobe  out  1  one-clk pulse when a data byte is written.
wr_index  out  log2(NUM_REGS)  register written; valid with wr_strobe.
busy  out  1  high from START to STOP.

Behaviour:
- Reset (asynchronous): all regs = 0, ptr = 0, sda_oe = 0, wr_strobe = 0, busy = 0, state = IDLE, synchronizers cleared to 1.
- Conditions are evaluated on the synchronized signals s_scl and s_sda:
  - SCL rise/fall: edge of s_scl.
  - START: s_sda falls while s_scl = 1.
  - STOP: s_sda rises while s_scl = 1.
- Bit timing: data bits are sampled on the SCL rise; sda_oe changes only on the SCL fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START, from any state (repeated start included) -> ADDR.
  - Clears the bit count; ptr is retained; busy = 1.
- STOP, from any state -> IDLE.
  - sda_oe = 0, busy = 0; a partially shifted byte is discarded with no write.
- ADDR: shift 8 bits, MSB first (7 address bits + R/W).
  - Match and W -> ADDR_ACK, then PTR.
  - Match and R -> ADDR_ACK, then RDATA.
  - Mismatch -> IGNORE: sda_oe stays 0 until the next START or STOP.
- ACK slot: on the SCL fall after the 8th bit, sda_oe = 1; on the next SCL fall, sda_oe = 0.
- PTR: received byte -> ptr = byte mod NUM_REGS; ACK it; then -> WDATA.
- WDATA: on the 8th SCL rise:
  - regs[ptr] = byte, wr_strobe = 1 for one clk, wr_index = ptr.
  - ptr increments and wraps mod NUM_REGS.
  - ACK the byte; stay in WDATA for burst writes.
- RDATA:
  - On entry, load a shift register with regs[ptr].
  - On each SCL fall, sda_oe = ~bit, MSB first, starting at the fall that ends the ACK slot.
  - After 8 bits, release SDA and sample the master's bit on the SCL rise (RDATA_ACK).
  - Master ACK (0): ptr++ with wrap; load the next byte; back to RDATA.
  - Master NACK (1) -> IGNORE.
- Write and read of the same register in one clk cannot occur, because a transaction is one direction only.
- Reset asserted mid-transfer forces sda_oe = 0 immediately, without waiting for a clk edge.

Test Plan:
- Single write: START, 0xE0, 0x01, 0xB2, STOP -> ACK on all 3 bytes; regs[1] = 0xB2, others 0; exactly one wr_strobe with wr_index = 1; busy returns to 0.
- Burst write with wrap: START, 0xE0, 0x03, 0x11, 0x22, STOP -> regs[3] = 0x11, regs[0] = 0x22; two wr_strobe pulses with index 3 then 0.
- Read with repeated start: preload regs[1] = 0xB2 and regs[2] = 0x5A; START, 0xE0, 0x01, Sr, 0xE1; master ACKs byte 1 and NACKs byte 2 -> SDA shows 0xB2 then 0x5A; sda_oe = 0 after the NACK until STOP.
- Address mismatch: START, 0xE2, 0x00, 0xFF, STOP -> sda_oe = 0 throughout; no wr_strobe; regs unchanged.
- STOP mid-byte: START, 0xE0, 0x00, then 4 data bits, then STOP -> no write, busy = 0; a following normal write of 0x77 to reg 0 succeeds.
- Async reset mid-read: assert reset while sda_oe = 1 -> sda_oe = 0 before the next clk edge; all regs = 0; busy = 0.
